reload_timer: RTL and testbench

//  Parametrised down-counting timer for the WSN SoC cell library; successor to the fixed 16-bit preset/enable/zero timer.

---
 rtl/reload_timer_if.sv | 28 ++
 rtl/reload_timer.sv | 102 ++++++++++
 tb/tb_reload_timer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/reload_timer_if.sv
// Control and status bundle for reload_timer. The controller side uses master and the
// timer uses slave.
interface reload_timer_if #(
  parameter int Width    = 16,
  parameter int PreWidth = 8
);
  logic                preset_i;
  logic                enable_i;
  logic                mode_i;
  logic [Width-1:0]    preset_val_i;
  logic [PreWidth-1:0] prescale_i;
  logic                clear_i;
  logic [Width-1:0]    value_o;
  logic                zero_o;
  logic                expired_o;
  logic                sticky_o;
  logic                running_o;

  modport master (
    output preset_i, enable_i, mode_i, preset_val_i, prescale_i, clear_i,
    input  value_o, zero_o, expired_o, sticky_o, running_o
  );

  modport slave (
    input  preset_i, enable_i, mode_i, preset_val_i, prescale_i, clear_i,
    output value_o, zero_o, expired_o, sticky_o, running_o
  );
endinterface

// File: rtl/reload_timer.sv
// Down-counting wake-up/interval timer with prescaler, one-shot or periodic reload,
// an expiry pulse and a sticky expiry flag.
//
// state | meaning
// IDLE  | after reset, waiting for a preset
// RUN   | counting ticks toward expiry
// DONE  | one-shot finished or zero preset; waits for the next preset
module reload_timer #(
  parameter int Width    = 16,
  parameter int PreWidth = 8
) (
  input  logic            Clk_i,
  input  logic            Reset_n_i,
  reload_timer_if.slave   tif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [Width-1:0]    ValOne = Width'(1);
  localparam logic [PreWidth-1:0] PreOne = PreWidth'(1);

  state_t              state_q,   state_d;
  logic [Width-1:0]    value_q,   value_d;
  logic [Width-1:0]    reload_q,  reload_d;
  logic [PreWidth-1:0] pre_cnt_q, pre_cnt_d;
  logic [PreWidth-1:0] pre_reg_q, pre_reg_d;
  logic                mode_q,    mode_d;
  logic                expired_q, expired_d;
  logic                sticky_q,  sticky_d;

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q   <= ST_IDLE;
      value_q   <= '0;
      reload_q  <= '0;
      pre_cnt_q <= '0;
      pre_reg_q <= '0;
      mode_q    <= 1'b0;
      expired_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      reload_q  <= reload_d;
      pre_cnt_q <= pre_cnt_d;
      pre_reg_q <= pre_reg_d;
      mode_q    <= mode_d;
      expired_q <= expired_d;
      sticky_q  <= sticky_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    reload_d  = reload_q;
    pre_cnt_d = pre_cnt_q;
    pre_reg_d = pre_reg_q;
    mode_d    = mode_q;
    expired_d = 1'b0;
    sticky_d  = tif.clear_i ? 1'b0 : sticky_q;

    // A preset overrides everything, including an expiry due in this same cycle.
    if (tif.preset_i) begin
      value_d   = tif.preset_val_i;
      reload_d  = tif.preset_val_i;
      pre_cnt_d = tif.prescale_i;
      pre_reg_d = tif.prescale_i;
      mode_d    = tif.mode_i;
      state_d   = (tif.preset_val_i != '0) ? ST_RUN : ST_DONE;
    end else if (state_q == ST_RUN && tif.enable_i) begin
      if (pre_cnt_q != '0) begin
        pre_cnt_d = pre_cnt_q - PreOne;
      end else begin
        pre_cnt_d = pre_reg_q;
        if (value_q > ValOne) begin
          value_d = value_q - ValOne;
        end else if (value_q == ValOne) begin
          expired_d = 1'b1;
          sticky_d  = 1'b1;
          if (mode_q) begin
            value_d = reload_q;
          end else begin
            value_d = '0;
            state_d = ST_DONE;
          end
        end
      end
    end
  end

  assign tif.value_o   = value_q;
  assign tif.zero_o    = (value_q == '0);
  assign tif.expired_o = expired_q;
  assign tif.sticky_o  = sticky_q;
  assign tif.running_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_reload_timer.sv
// Self-checking bench for reload_timer: directed scenarios plus randomized traffic
// compared every cycle against a tick-counting reference model.
module tb_reload_timer;

  localparam int W  = 16;
  localparam int PW = 8;

  logic clk;
  logic rst_n;

  reload_timer_if #(.Width(W), .PreWidth(PW)) tif();

  reload_timer #(.Width(W), .PreWidth(PW)) dut (
    .Clk_i     (clk),
    .Reset_n_i (rst_n),
    .tif       (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the time to the next tick is a countdown of enabled clocks,
  // expiry happens when the tick count reaches zero.
  int m_val, m_reload, m_wait, m_period_m1, m_mode;
  bit m_run, m_exp, m_sticky;

  function automatic void model_reset();
    m_val = 0; m_reload = 0; m_wait = 0; m_period_m1 = 0; m_mode = 0;
    m_run = 0; m_exp = 0; m_sticky = 0;
  endfunction

  function automatic void model_step(bit pre, bit en, bit mode, int pv, int ps, bit clr);
    bit fire;
    fire = 0;
    if (pre) begin
      m_val = pv; m_reload = pv; m_wait = ps; m_period_m1 = ps; m_mode = mode;
      m_run = (pv != 0);
    end else if (m_run && en) begin
      if (m_wait > 0) m_wait--;
      else begin
        m_wait = m_period_m1;
        m_val--;
        if (m_val == 0) begin
          fire = 1;
          if (m_mode != 0) m_val = m_reload;
          else m_run = 0;
        end
      end
    end
    m_exp = fire;
    if (fire) m_sticky = 1;
    else if (clr) m_sticky = 0;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".value"},   int'(tif.value_o),   m_val);
    check({tag, ".zero"},    int'(tif.zero_o),    int'(m_val == 0));
    check({tag, ".expired"}, int'(tif.expired_o), int'(m_exp));
    check({tag, ".sticky"},  int'(tif.sticky_o),  int'(m_sticky));
    check({tag, ".running"}, int'(tif.running_o), int'(m_run));
  endtask

  // Apply inputs at the falling edge, clock once, then compare at the next falling edge.
  task automatic cyc(input string tag, input bit pre, input bit en, input bit mode,
                     input int pv, input int ps, input bit clr);
    tif.preset_i     = pre;
    tif.enable_i     = en;
    tif.mode_i       = mode;
    tif.preset_val_i = W'(pv);
    tif.prescale_i   = PW'(ps);
    tif.clear_i      = clr;
    @(posedge clk);
    model_step(pre, en, mode, pv, ps, clr);
    @(negedge clk);
    compare_all(tag);
  endtask

  int pulses, zeros;

  initial begin
    rst_n = 1'b0;
    tif.preset_i = 0; tif.enable_i = 0; tif.mode_i = 0;
    tif.preset_val_i = '0; tif.prescale_i = '0; tif.clear_i = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    check("reset.zero_const", int'(tif.zero_o), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // One-shot 3 ticks, no prescale
    cyc("s1", 1, 1, 0, 3, 0, 0);
    check("s1.load", int'(tif.value_o), 3);
    cyc("s1", 0, 1, 0, 0, 0, 0);
    check("s1.v2", int'(tif.value_o), 2);
    cyc("s1", 0, 1, 0, 0, 0, 0);
    check("s1.v1", int'(tif.value_o), 1);
    check("s1.no_exp_yet", int'(tif.expired_o), 0);
    cyc("s1", 0, 1, 0, 0, 0, 0);
    check("s1.v0", int'(tif.value_o), 0);
    check("s1.exp", int'(tif.expired_o), 1);
    check("s1.zero", int'(tif.zero_o), 1);
    check("s1.stopped", int'(tif.running_o), 0);
    cyc("s1", 0, 1, 0, 0, 0, 0);
    check("s1.exp_once", int'(tif.expired_o), 0);

    // Periodic: 2 ticks of 4 clocks -> pulse every 8 clocks
    cyc("s2", 1, 1, 1, 2, 3, 0);
    pulses = 0; zeros = 0;
    for (int i = 1; i <= 24; i++) begin
      cyc("s2", 0, 1, 0, 0, 0, 0);
      if (tif.expired_o) pulses++;
      if (tif.zero_o) zeros++;
      if (i == 8 || i == 16) check("s2.pulse_slot", int'(tif.expired_o), 1);
      if (i == 4) check("s2.v1_at4", int'(tif.value_o), 1);
      if (i == 3) check("s2.v2_at3", int'(tif.value_o), 2);
    end
    check("s2.pulses", pulses, 3);
    check("s2.zeros", zeros, 0);

    // One-shot 5 with enable dropped for 4 cycles at value 3
    cyc("s3", 1, 1, 0, 5, 0, 0);
    cyc("s3", 0, 1, 0, 0, 0, 0);
    cyc("s3", 0, 1, 0, 0, 0, 0);
    check("s3.at3", int'(tif.value_o), 3);
    for (int i = 0; i < 4; i++) cyc("s3", 0, 0, 0, 0, 0, 0);
    check("s3.frozen", int'(tif.value_o), 3);
    cyc("s3", 0, 1, 0, 0, 0, 0);
    cyc("s3", 0, 1, 0, 0, 0, 0);
    check("s3.not_early", int'(tif.expired_o), 0);
    cyc("s3", 0, 1, 0, 0, 0, 0);
    check("s3.exp_delayed", int'(tif.expired_o), 1);

    // Zero preset: DONE, no pulse, sticky held
    cyc("s4", 1, 1, 0, 0, 2, 0);
    check("s4.zero", int'(tif.zero_o), 1);
    check("s4.run", int'(tif.running_o), 0);
    check("s4.exp", int'(tif.expired_o), 0);
    check("s4.sticky_kept", int'(tif.sticky_o), 1);

    // Expiry with simultaneous clear
    cyc("s5", 1, 1, 0, 2, 0, 1);
    check("s5.cleared", int'(tif.sticky_o), 0);
    cyc("s5", 0, 1, 0, 0, 0, 0);
    cyc("s5", 0, 1, 0, 0, 0, 1);
    check("s5.set_wins", int'(tif.sticky_o), 1);
    cyc("s5", 0, 0, 0, 0, 0, 1);
    check("s5.clear", int'(tif.sticky_o), 0);

    // Preset on the expiry cycle discards the expiry
    cyc("s6", 1, 1, 0, 2, 0, 0);
    cyc("s6", 0, 1, 0, 0, 0, 0);
    cyc("s6", 1, 1, 0, 7, 1, 0);
    check("s6.no_exp", int'(tif.expired_o), 0);
    check("s6.newval", int'(tif.value_o), 7);
    check("s6.no_sticky", int'(tif.sticky_o), 0);
    cyc("s6", 0, 1, 0, 0, 0, 0);
    cyc("s6", 0, 1, 0, 0, 0, 0);

    // Asynchronous reset mid-count
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    check("async_rst.value", int'(tif.value_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit pre, en, mode, clr;
      int pv, ps;
      pre  = ($urandom_range(0, 15) == 0);
      en   = ($urandom_range(0, 3) != 0);
      mode = $urandom_range(0, 1);
      clr  = ($urandom_range(0, 11) == 0);
      pv   = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 6);
      ps   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
      cyc("rnd", pre, en, mode, pv, ps, clr);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
